// File: rtl/muldiv_ctrl.sv
// Purpose : iterative MIPS HI/LO sequencer for MULT/MULTU/DIV/DIVU in EX.
// Latency : accept at T, one radix-2 step per cycle T+1..T+32, HI/LO write at T+33.
// Backpr. : holds the pipeline with stall_req from T to T+32; releases it in the write cycle.
//
// Ports: clk/rst (async active-high); op_valid, funct, operand_a, operand_b from EX;
//        flush aborts a running op; stall_req, busy, hi_lo_we, hi, lo outputs.
// Option: define MULDIV_FAST_MUL_EN to compute MULT/MULTU in one cycle (IDLE -> DONE).
module muldiv_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              stall_req,
    output logic              busy,
    output logic              hi_lo_we,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] work_q;     // mul: {partial high, multiplier}; div: {remainder, quotient}
    logic [DATA_W-1:0]   b_q;        // multiplicand / divisor magnitude
    logic                is_div_q;
    logic                neg_lo_q;   // negate product (mul) or quotient (div)
    logic                neg_hi_q;   // negate remainder (div only)

    // funct 6'h18..6'h1B: bit1 selects divide, bit0 selects unsigned
    logic              op_ok, accept, is_div_in, is_signed_in, a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;

    assign op_ok        = (funct[5:2] == 4'b0110);
    assign accept       = (state_q == S_IDLE) && op_valid && !flush && op_ok;
    assign is_div_in    = funct[1];
    assign is_signed_in = !funct[0];
    assign a_neg        = is_signed_in && operand_a[DATA_W-1];
    assign b_neg        = is_signed_in && operand_b[DATA_W-1];
    assign a_mag        = a_neg ? -operand_a : operand_a;
    assign b_mag        = b_neg ? -operand_b : operand_b;

    // One iteration step
    logic [DATA_W:0]     mul_sum, div_shift, div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] work_step;
    logic [DATA_W-1:0]   res_hi, res_lo;

    always_comb begin
        mul_sum   = {1'b0, work_q[2*DATA_W-1:DATA_W]} + (work_q[0] ? {1'b0, b_q} : '0);
        div_shift = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, b_q};
        // The remainder stays below the divisor, so the shifted value is below
        // 2*divisor and bit DATA_W of the difference is a pure borrow. With a
        // zero divisor the remainder only ever holds the dividend bits shifted
        // in so far, so the top bit stays clear and every step "succeeds".
        div_ge    = !div_diff[DATA_W];
        if (is_div_q) begin
            work_step = {(div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                         work_q[DATA_W-2:0], div_ge};
        end else begin
            work_step = {mul_sum, work_q[DATA_W-1:1]};
        end
    end

    // Sign correction applied to the final step's result
    always_comb begin
        res_hi = work_step[2*DATA_W-1:DATA_W];
        res_lo = work_step[DATA_W-1:0];
        if (is_div_q) begin
            if (neg_lo_q) res_lo = -work_step[DATA_W-1:0];
            if (neg_hi_q) res_hi = -work_step[2*DATA_W-1:DATA_W];
        end else if (neg_lo_q) begin
            {res_hi, res_lo} = -work_step;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extending to full width lets one unsigned multiply serve both MULT and MULTU
    logic [2*DATA_W-1:0] ext_a, ext_b, fast_prod;
    assign ext_a     = {{DATA_W{a_neg}}, operand_a};
    assign ext_b     = {{DATA_W{b_neg}}, operand_b};
    assign fast_prod = ext_a * ext_b;
`endif

    always_comb begin
        state_d   = state_q;
        stall_req = 1'b0;
        hi_lo_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    stall_req = 1'b1;
                    state_d   = S_CALC;
`ifdef MULDIV_FAST_MUL_EN
                    if (!is_div_in) state_d = S_DONE;
`endif
                end
            end
            S_CALC: begin
                stall_req = 1'b1;
                if (flush)                    state_d = S_IDLE;
                else if (cnt_q == LAST_STEP)  state_d = S_DONE;
            end
            S_DONE: begin
                hi_lo_we = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            work_q   <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (accept) begin
            cnt_q    <= '0;
            work_q   <= {{DATA_W{1'b0}}, a_mag};
            b_q      <= b_mag;
            is_div_q <= is_div_in;
            // A zero divisor yields an all-ones quotient that is never negated
            neg_lo_q <= (a_neg ^ b_neg) && !(is_div_in && (operand_b == '0));
            neg_hi_q <= a_neg;
`ifdef MULDIV_FAST_MUL_EN
            if (!is_div_in) begin
                hi <= fast_prod[2*DATA_W-1:DATA_W];
                lo <= fast_prod[DATA_W-1:0];
            end
`endif
        end else if (state_q == S_CALC && !flush) begin
            work_q <= work_step;
            cnt_q  <= cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Purpose : self-checking bench for muldiv_ctrl against an arithmetic reference model.
// Latency : expects the write at T+33 (T+1 for multiplies when MULDIV_FAST_MUL_EN is defined).
// Backpr. : checks stall_req/busy/hi_lo_we cycle by cycle around each operation.
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [5:0]  funct;
    logic [31:0] operand_a, operand_b;
    logic        flush;
    logic        stall_req, busy, hi_lo_we;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_hi = 32'h0;
    logic [31:0] last_lo = 32'h0;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    muldiv_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .funct     (funct),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .hi_lo_we  (hi_lo_we),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: MIPS HI/LO semantics computed with plain 64-bit arithmetic
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mh, output logic [31:0] ml);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'h0;
        case (f)
            6'h18: p = sa * sb;
            6'h19: p = {32'h0, a} * {32'h0, b};
            6'h1A: begin
                if (b == 32'h0) begin
                    p = {a, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            6'h1B: begin
                if (b == 32'h0) p = {a, 32'hFFFFFFFF};
                else            p = {a % b, a / b};
            end
            default: p = 64'h0;
        endcase
        mh = p[63:32];
        ml = p[31:0];
    endfunction

    // Runs one complete operation from the accept cycle through the write cycle.
    // Junk operands with op_valid held high during CALC/DONE must be ignored.
    task automatic test_one_op(input string name, input logic [5:0] f, input logic [31:0] a,
                               input logic [31:0] b, input bit flush_in_done);
        logic [31:0] eh, el;
        int lat;
        model(f, a, b, eh, el);
        lat = (FAST && !f[1]) ? 1 : 33;
        @(negedge clk);
        op_valid = 1'b1; funct = f; operand_a = a; operand_b = b; flush = 1'b0;
        #1;
        total++;
        if (stall_req !== 1'b1 || busy !== 1'b0 || hi_lo_we !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: stall=%b busy=%b we=%b, required 1 0 0", name, stall_req, busy, hi_lo_we);
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            operand_a = $urandom;
            operand_b = $urandom;
            funct     = 6'h18 + 6'($urandom_range(0, 3));
            flush     = flush_in_done && (k == lat);
            #1;
            total++;
            if (stall_req !== (k < lat) || busy !== 1'b1 || hi_lo_we !== (k == lat)) begin
                bad++;
                $display("FAIL %s cycle T+%0d: stall=%b busy=%b we=%b, required %b 1 %b",
                         name, k, stall_req, busy, hi_lo_we, (k < lat), (k == lat));
            end
            if (k == lat) begin
                total++;
                if (hi !== eh || lo !== el) begin
                    bad++;
                    $display("FAIL %s result: hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, eh, el);
                end
            end
        end
        #1;
        op_valid = 1'b0;
        flush    = 1'b0;
        last_hi  = eh;
        last_lo  = el;
    endtask

    task automatic test_reset;
        rst = 1'b1; op_valid = 1'b0; funct = 6'h0; operand_a = 32'h0; operand_b = 32'h0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (stall_req !== 1'b0 || busy !== 1'b0 || hi_lo_we !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            bad++;
            $display("FAIL reset: stall=%b busy=%b we=%b hi=%h lo=%h, required all zero",
                     stall_req, busy, hi_lo_we, hi, lo);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul;
        test_one_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'h00000002, 1'b0);
        test_one_op("mult_neg", 6'h18, 32'hFFFFFFFD, 32'h00000007, 1'b0);
        test_one_op("mult_both_neg", 6'h18, 32'h80000000, 32'h80000000, 1'b0);
    endtask

    task automatic test_div;
        test_one_op("div_neg", 6'h1A, 32'hFFFFFFF9, 32'h00000002, 1'b0);
        test_one_op("div_ovf", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        test_one_op("divu_big", 6'h1B, 32'hFFFFFFFF, 32'h00000010, 1'b0);
    endtask

    task automatic test_div_zero;
        test_one_op("divu_zero", 6'h1B, 32'd100, 32'h0, 1'b0);
        test_one_op("div_zero_neg", 6'h1A, 32'hFFFFFFFB, 32'h0, 1'b0);
    endtask

    task automatic test_no_accept;
        @(negedge clk);
        op_valid = 1'b1; funct = 6'h10; operand_a = 32'd9; operand_b = 32'd9; flush = 1'b0;
        #1;
        total++;
        if (stall_req !== 1'b0) begin
            bad++;
            $display("FAIL illegal_funct stall: got %b, required 0", stall_req);
        end
        @(negedge clk);
        funct = 6'h18; flush = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || stall_req !== 1'b0) begin
            bad++;
            $display("FAIL flush_accept: busy=%b stall=%b, required 0 0", busy, stall_req);
        end
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_accept busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_flush;
        logic [31:0] ph, pl;
        ph = last_hi;
        pl = last_lo;
        @(negedge clk);
        op_valid = 1'b1; funct = 6'h1B; operand_a = 32'd10; operand_b = 32'd3; flush = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            op_valid = 1'b0;
            flush    = (k == 10);
            #1;
            total++;
            if (hi_lo_we !== 1'b0 || busy !== (k <= 10) || stall_req !== (k <= 10)) begin
                bad++;
                $display("FAIL flush T+%0d: we=%b busy=%b stall=%b, required 0 %b %b",
                         k, hi_lo_we, busy, stall_req, (k <= 10), (k <= 10));
            end
        end
        flush = 1'b0;
        total++;
        if (hi !== ph || lo !== pl) begin
            bad++;
            $display("FAIL flush hold: hi=%h lo=%h, required hi=%h lo=%h", hi, lo, ph, pl);
        end
        test_one_op("multu_after_flush", 6'h19, 32'd5, 32'd6, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [5:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            test_one_op("random", f, a, b, ($urandom_range(0, 2) == 0));
        end
    endtask

    task automatic test_rst_mid;
        @(negedge clk);
        op_valid = 1'b1; operand_a = 32'd5; operand_b = 32'd6; flush = 1'b0;
        funct = FAST ? 6'h1B : 6'h19;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        total++;
        if (stall_req !== 1'b0 || busy !== 1'b0 || hi_lo_we !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid: stall=%b busy=%b we=%b hi=%h lo=%h, required all zero",
                     stall_req, busy, hi_lo_we, hi, lo);
        end
        for (int k = 6; k <= 40; k++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            total++;
            if (hi_lo_we !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid T+%0d: we=%b busy=%b, required 0 0", k, hi_lo_we, busy);
            end
        end
        test_one_op("multu_after_rst", 6'h19, 32'd5, 32'd6, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_no_accept();
        test_flush();
        test_back_to_back();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative sequencer for the MIPS HI/LO multiply/divide operations in the EX stage: MULT, MULTU, DIV and DIVU.
- Accepts one operation from EX, holds the pipeline through a stall request while it iterates, then issues a single HI/LO write pulse.
- Selects the operation from the 6-bit funct code that the ID-stage funct generator produces for SPECIAL-opcode instructions.

Parameters:
- DATA_W, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- op_valid  input  1  EX holds a valid instruction.
- funct  input  6  EX funct code: MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B; any other value is ignored.
- operand_a  input  DATA_W  rs value (multiplicand / dividend).
- operand_b  input  DATA_W  rt value (multiplier / divisor).
- flush  input  1  pipeline flush; aborts any operation in progress.
- stall_req  output  1  stall request to the pipeline controller.
- busy  output  1  state is not IDLE.
- hi_lo_we  output  1  single-cycle HI/LO write enable.
- hi  output  DATA_W  HI result (product high word / remainder).
- lo  output  DATA_W  LO result (product low word / quotient).

Behaviour:
- Reset values: state IDLE; stall_req, busy, hi_lo_we = 0; hi, lo, counter and internal registers = 0.
- States:
  - IDLE -> CALC when op_valid=1, flush=0 and funct is one of the four codes (the accept cycle). Operands, op kind and sign flags latch; signed ops latch operand magnitudes; counter = 0.
  - CALC: one radix-2 step per cycle. Shift-add for multiply; restoring shift-subtract for divide. CALC -> DONE after the step with counter = DATA_W-1, i.e. 32 cycles.
  - DONE: hi_lo_we = 1 for exactly one cycle; hi/lo valid, sign-corrected. DONE -> IDLE unconditionally.
- Cycle timing, with T = accept cycle: CALC occupies T+1..T+32; DONE is T+33.
- stall_req is combinational: (IDLE and accept condition) or state == CALC. It is high T..T+32 and low at T+33, so EX advances while the write occurs.
- op_valid is ignored in CALC and DONE. A new op may be accepted at T+34 at the earliest.
- Sign rules:
  - MULT: product is negated iff the operand signs differ.
  - DIV: quotient is negated iff the operand signs differ; remainder takes the dividend's sign.
  - Unsigned ops use raw operands.
- -2^31 / -1 (DIV): LO = 32'h80000000, HI = 0. This falls out of the magnitude path with no special case.
- Divide by zero (DIV/DIVU): full 32-cycle latency; LO = 32'hFFFFFFFF, HI = operand_a. No exception.
- Flush:
  - In CALC: next state IDLE, no hi_lo_we, hi/lo unchanged.
  - In the accept cycle: no accept.
  - In DONE: the write still completes.
- rst asserted mid-operation: immediate return to reset values; no write.
- hi/lo hold their last value outside DONE.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute with a single-cycle full-width multiply and go IDLE -> DONE directly. stall_req is high in cycle T only; hi_lo_we is high at T+1.
  - DIV/DIVU timing is unchanged.
- Undefined: all four ops use the 32-cycle iterative path.

Test Plan:
- MULTU a=32'hFFFFFFFF, b=32'h00000002 -> stall_req high T..T+32; hi_lo_we only at T+33; HI=32'h00000001, LO=32'hFFFFFFFE.
- MULT a=-3 (32'hFFFFFFFD), b=7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
- DIV a=-7, b=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
- DIV a=32'h80000000, b=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- DIVU a=100, b=0 -> LO=32'hFFFFFFFF, HI=100 at T+33.
- DIVU a=10, b=3: flush at T+10 -> IDLE at T+11, no hi_lo_we, hi/lo keep their prior value. Then MULTU 5x6 accepted at T+12 -> HI=0, LO=30 at T+45.
- MULTU 5x6 with rst pulsed at T+5 -> all outputs 0 immediately, no hi_lo_we.
- MULTU 5x6 with MULDIV_FAST_MUL_EN defined -> hi_lo_we at T+1, LO=30.
